// File: rtl/branch_redirect_unit.sv
// Branch resolution and PC redirect control. A taken branch registers its target,
// asserts PCSource for one unstalled cycle and Flush for FLUSH_CYCLES unstalled cycles.
module branch_redirect_unit #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BranchValid,
    input  logic [2:0]       BranchOp,
    input  logic [WIDTH-1:0] RsData,
    input  logic [WIDTH-1:0] RtData,
    input  logic [WIDTH-1:0] PCPlus4,
    input  logic [15:0]      Offset,
    input  logic [25:0]      JumpIndex,
    input  logic             Stall,
    output logic             PCSource,
    output logic [WIDTH-1:0] BranchTarget,
    output logic             Flush,
    output logic [15:0]      BranchCount,
    output logic [15:0]      TakenCount
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [2:0]       flush_cnt_r;
    logic [2:0]       flush_cnt_nxt_s;
    logic             taken_s;
    logic             rs_neg_s;
    logic             rs_zero_s;
    logic [WIDTH-1:0] offset_ext_s;
    logic [WIDTH-1:0] cond_target_s;
    logic [WIDTH-1:0] jump_target_s;
    logic [WIDTH-1:0] target_s;
    logic             pc_source_nxt_s;
    logic             flush_nxt_s;
    logic [WIDTH-1:0] target_nxt_s;
    logic [15:0]      branch_count_nxt_s;
    logic [15:0]      taken_count_nxt_s;

    assign rs_neg_s      = RsData[WIDTH-1];
    assign rs_zero_s     = (RsData == {WIDTH{1'b0}});
    assign offset_ext_s  = {{(WIDTH-18){Offset[15]}}, Offset, 2'b00};
    assign cond_target_s = PCPlus4 + offset_ext_s;
    assign jump_target_s = {PCPlus4[WIDTH-1:28], JumpIndex, 2'b00};
    assign target_s      = (BranchOp == 3'd6) ? jump_target_s : cond_target_s;

    // Branch condition evaluation; reserved op is never taken
    always_comb begin
        taken_s = 1'b0;
        case (BranchOp)
            3'd0:    taken_s = (RsData == RtData);
            3'd1:    taken_s = (RsData != RtData);
            3'd2:    taken_s = rs_neg_s || rs_zero_s;
            3'd3:    taken_s = !rs_neg_s && !rs_zero_s;
            3'd4:    taken_s = rs_neg_s;
            3'd5:    taken_s = !rs_neg_s;
            3'd6:    taken_s = 1'b1;
            default: taken_s = 1'b0;
        endcase
    end

    // State register plus registered outputs and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            flush_cnt_r  <= 3'd0;
            PCSource     <= 1'b0;
            Flush        <= 1'b0;
            BranchTarget <= {WIDTH{1'b0}};
            BranchCount  <= 16'd0;
            TakenCount   <= 16'd0;
        end else begin
            state_r      <= state_nxt_s;
            flush_cnt_r  <= flush_cnt_nxt_s;
            PCSource     <= pc_source_nxt_s;
            Flush        <= flush_nxt_s;
            BranchTarget <= target_nxt_s;
            BranchCount  <= branch_count_nxt_s;
            TakenCount   <= taken_count_nxt_s;
        end
    end

    // Next-state logic; flush_cnt counts Flush cycles already presented
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        if (Stall) begin
            state_nxt_s     = state_r;
            flush_cnt_nxt_s = flush_cnt_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (BranchValid && taken_s) begin
                        state_nxt_s     = REDIRECT;
                        flush_cnt_nxt_s = 3'd1;
                    end else begin
                        state_nxt_s     = IDLE;
                        flush_cnt_nxt_s = 3'd0;
                    end
                end
                REDIRECT: begin
                    if (FLUSH_LAST == 3'd1) begin
                        state_nxt_s     = IDLE;
                        flush_cnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s     = FLUSH;
                        flush_cnt_nxt_s = 3'd2;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_r >= FLUSH_LAST) begin
                        state_nxt_s     = IDLE;
                        flush_cnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s     = FLUSH;
                        flush_cnt_nxt_s = flush_cnt_r + 3'd1;
                    end
                end
                default: begin
                    state_nxt_s     = IDLE;
                    flush_cnt_nxt_s = 3'd0;
                end
            endcase
        end
    end

    // Output and counter next values; branches outside IDLE are wrong-path and ignored
    always_comb begin
        pc_source_nxt_s    = PCSource;
        flush_nxt_s        = Flush;
        target_nxt_s       = BranchTarget;
        branch_count_nxt_s = BranchCount;
        taken_count_nxt_s  = TakenCount;
        if (Stall) begin
            pc_source_nxt_s = PCSource;
            flush_nxt_s     = Flush;
        end else begin
            case (state_r)
                IDLE: begin
                    if (BranchValid) begin
                        branch_count_nxt_s = BranchCount + 16'd1;
                        if (taken_s) begin
                            taken_count_nxt_s = TakenCount + 16'd1;
                            target_nxt_s      = target_s;
                            pc_source_nxt_s   = 1'b1;
                            flush_nxt_s       = 1'b1;
                        end else begin
                            pc_source_nxt_s = 1'b0;
                            flush_nxt_s     = 1'b0;
                        end
                    end else begin
                        pc_source_nxt_s = 1'b0;
                        flush_nxt_s     = 1'b0;
                    end
                end
                REDIRECT: begin
                    pc_source_nxt_s = 1'b0;
                    flush_nxt_s     = (FLUSH_LAST != 3'd1);
                end
                FLUSH: begin
                    pc_source_nxt_s = 1'b0;
                    if (flush_cnt_r >= FLUSH_LAST) begin
                        flush_nxt_s = 1'b0;
                    end else begin
                        flush_nxt_s = 1'b1;
                    end
                end
                default: begin
                    pc_source_nxt_s = 1'b0;
                    flush_nxt_s     = 1'b0;
                end
            endcase
        end
    end

endmodule
